// File: rtl/posit_pkg.sv
// posit_pkg: shared posit-64 (es=4) decode constants and the decoded-field record.
package posit_pkg;
  localparam int N  = 64;
  localparam int ES = 4;
  localparam int RS = 7;
  localparam int FS = N - ES - 3;
  localparam int SS = RS + ES;
  typedef struct packed {
    logic          sign;
    logic          zero;
    logic          nar;
    logic [SS-1:0] scale;
    logic [FS:0]   mant;
  } posit_dec_t;
endpackage

// File: rtl/posit_skid_buf.sv
// posit_skid_buf: 2-entry valid/ready FIFO whose in_ready depends only on registered occupancy.
module posit_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [1:0]   cnt;
  logic [W-1:0] head, tail;
  logic         push, pop;
  assign in_ready  = cnt != 2'd2;
  assign out_valid = cnt != 2'd0;
  assign out_data  = head;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      cnt <= cnt + 2'(push) - 2'(pop);
      if (push && (cnt == 2'd0 || pop))
        head <= in_data;
      else if (pop && cnt == 2'd2)
        head <= tail;
      if (push)
        tail <= in_data;
    end
  end
endmodule

// File: rtl/posit_scale_stage.sv
// posit_scale_stage: merges regime/exponent into a signed scale, adds the hidden bit, and registers via a skid buffer.
module posit_scale_stage
  import posit_pkg::*;
#(
  parameter int N  = 64,
  parameter int ES = 4,
  parameter int RS = 7,
  parameter int FS = N - ES - 3,
  parameter int SS = RS + ES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic          in_zero,
  input  logic          in_nar,
  input  logic [RS-1:0] in_regi,
  input  logic [ES-1:0] in_expo,
  input  logic [FS-1:0] in_frac,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic          out_zero,
  output logic          out_nar,
  output logic [SS-1:0] out_scale,
  output logic [FS:0]   out_mant,
  output logic [15:0]   nar_count
);
  posit_dec_t d, q;
  logic       special;
  assign special = in_zero || in_nar;
  // k*2^ES + e in RS+ES bits is exactly the concatenation {k, e}
  always_comb begin
    d       = '0;
    d.sign  = in_sign;
    d.nar   = in_nar;
    d.zero  = in_zero && !in_nar;
    d.scale = special ? '0 : {in_regi, in_expo};
    d.mant  = special ? '0 : {1'b1, in_frac};
  end
  posit_skid_buf #(.W($bits(posit_dec_t))) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (q)
  );
  assign out_sign  = q.sign;
  assign out_zero  = q.zero;
  assign out_nar   = q.nar;
  assign out_scale = q.scale;
  assign out_mant  = q.mant;
  always_ff @(posedge clk) begin
    if (!rst_n)
      nar_count <= '0;
    else if (out_valid && out_ready && out_nar && nar_count != 16'hFFFF)
      nar_count <= nar_count + 16'd1;
  end
endmodule

// File: tb/tb_posit_scale_stage.sv
// tb_posit_scale_stage: directed vectors checked against a queue-based behavioural model plus literal expectations.
module tb_posit_scale_stage;
  import posit_pkg::*;
  logic          clk = 0;
  logic          rst_n = 0;
  logic          in_valid = 0, in_ready;
  logic          in_sign = 0, in_zero = 0, in_nar = 0;
  logic [RS-1:0] in_regi = '0;
  logic [ES-1:0] in_expo = '0;
  logic [FS-1:0] in_frac = '0;
  logic          out_valid, out_ready = 0;
  logic          out_sign, out_zero, out_nar;
  logic [SS-1:0] out_scale;
  logic [FS:0]   out_mant;
  logic [15:0]   nar_count;
  int            n_cmp = 0, n_bad = 0, pops = 0;
  bit            armed = 0;
  posit_dec_t    mq[$];
  logic [15:0]   nar_m = 0;

  posit_scale_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_zero(in_zero), .in_nar(in_nar), .in_regi(in_regi),
    .in_expo(in_expo), .in_frac(in_frac), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_zero(out_zero), .out_nar(out_nar), .out_scale(out_scale),
    .out_mant(out_mant), .nar_count(nar_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic posit_dec_t model(input logic s, input logic z, input logic n,
                                       input int k, input int e, input logic [FS-1:0] f);
    posit_dec_t r;
    int sc;
    r.sign = s;
    r.nar  = n;
    r.zero = z && !n;
    sc     = k * 16 + e;
    r.scale = (z || n) ? '0 : SS'(sc);
    r.mant  = (z || n) ? '0 : {1'b1, f};
    return r;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      bit can_in, can_out;
      can_in  = mq.size() < 2;
      can_out = mq.size() != 0;
      chk("out_valid", 128'(out_valid), 128'(can_out));
      chk("in_ready", 128'(in_ready), 128'(can_in));
      chk("nar_count", 128'(nar_count), 128'(nar_m));
      if (can_out)
        chk("out_data", 128'({out_sign, out_zero, out_nar, out_scale, out_mant}), 128'(mq[0]));
      if (!rst_n) begin
        mq.delete();
        nar_m = 0;
      end else begin
        if (can_out && out_ready) begin
          if (mq[0].nar && nar_m != 16'hFFFF) nar_m++;
          void'(mq.pop_front());
          pops++;
        end
        if (in_valid && can_in)
          mq.push_back(model(in_sign, in_zero, in_nar, int'($signed(in_regi)), int'(in_expo), in_frac));
      end
    end
  end

  task automatic send(input logic s, input logic z, input logic n, input int k, input int e,
                      input logic [FS-1:0] f);
    int w = 0;
    in_valid = 1; in_sign = s; in_zero = z; in_nar = n;
    in_regi = RS'(k); in_expo = ES'(e); in_frac = f;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("send_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  initial begin
    int p0;
    @(posedge clk); #1;
    armed = 1;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    out_ready = 1;
    send(0, 0, 0, 2, 3, 57'h1);
    @(negedge clk);
    chk("pos_scale", 128'(out_scale), 128'(11'sd35));
    chk("pos_mant", 128'(out_mant), 128'(58'h200000000000001));
    @(posedge clk); #1;
    send(1, 0, 0, -3, 5, 57'hABC);
    @(negedge clk);
    chk("neg_scale", 128'(out_scale), 128'(11'h7D5));
    chk("neg_sign", 128'(out_sign), 128'(1));
    @(posedge clk); #1;
    send(0, 0, 1, 5, 7, 57'h123);
    @(negedge clk);
    chk("nar_scale_mant", 128'({out_scale, out_mant}), 128'(0));
    chk("nar_flag", 128'(out_nar), 128'(1));
    chk("nar_cnt_before", 128'(nar_count), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("nar_cnt_after", 128'(nar_count), 128'(1));
    @(posedge clk); #1;
    send(0, 1, 0, 9, 2, 57'h55);
    @(negedge clk);
    chk("zero_flag", 128'({out_zero, out_scale}), 128'({1'b1, 11'd0}));
    @(posedge clk); #1;
    send(1, 1, 1, 1, 1, 57'h1);
    @(negedge clk);
    chk("zero_nar_prio", 128'({out_zero, out_nar}), 128'(2'b01));
    @(posedge clk); #1;
    send(0, 0, 0, 61, 15, '1);
    send(0, 0, 0, -62, 0, '0);
    @(posedge clk); #1;
    // backpressure: A and B fill the buffer, A must hold until drained
    out_ready = 0;
    send(0, 0, 0, 1, 1, 57'hA);
    send(0, 0, 0, 2, 2, 57'hB);
    @(negedge clk);
    chk("bp_full", 128'(in_ready), 128'(0));
    chk("bp_hold_a", 128'(out_scale), 128'(11'd17));
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk);
    chk("bp_still_a", 128'(out_scale), 128'(11'd17));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_b_next", 128'(out_scale), 128'(11'd34));
    chk("bp_ready_back", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    @(negedge clk);
    p0 = pops;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++)
      send(i[0], 1'b0, (i % 13) == 7, (i * 5) % 124 - 62, i % 16, FS'(i * 32'h9E3779B1));
    repeat (3) begin @(posedge clk); #1; end
    chk("stream_count", 128'(pops - p0), 128'(100));
    fork
      begin
        for (int c = 0; c < 60; c++) begin
          out_ready = (c % 3) != 1;
          @(posedge clk); #1;
        end
      end
      for (int i = 0; i < 20; i++)
        send(1'b1, (i % 5) == 3, (i % 4) == 1, 30 - 3 * i, 15 - i % 16, FS'(i * 32'h1234567));
    join
    out_ready = 1;
    repeat (4) begin @(posedge clk); #1; end
    // reset with the buffer full discards both entries
    out_ready = 0;
    send(0, 0, 1, 3, 3, 57'h3);
    send(0, 0, 1, 4, 4, 57'h4);
    rst_n = 0;
    in_valid = 1;
    @(posedge clk); #1;
    rst_n = 1;
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    chk("rst_mid_valid", 128'(out_valid), 128'(0));
    chk("rst_mid_ready", 128'(in_ready), 128'(1));
    chk("rst_mid_narcnt", 128'(nar_count), 128'(0));
    chk("rst_mid_outs", 128'({out_sign, out_zero, out_nar, out_scale, out_mant}), 128'(0));
    repeat (5) begin @(posedge clk); #1; end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
